// File: rtl/poly_rq_to_s3.sv
// Streams an NTRU Rq polynomial in, reduces each centred coefficient mod 3, then streams out
// the ternary polynomial normalised so its top coefficient is zero (s_i = t_i - t_{N-1} mod 3).
module poly_rq_to_s3 #(
    parameter int NTRU_N = 701,
    parameter int Q_BITS = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Q_BITS-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_coef,
    output logic              out_last,
    output logic              busy
);

    localparam int             IW       = (NTRU_N > 1) ? $clog2(NTRU_N) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NTRU_N - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Residue of -2^Q_BITS mod 3, added when the coefficient centres to a negative value.
    localparam logic [1:0] NEG_ADJ = (Q_BITS % 2 == 0) ? 2'd2 : 2'd1;

    function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // MSB-first remainder: r <- (2r + bit) mod 3
    function automatic logic [1:0] mod3(input logic [Q_BITS-1:0] a);
        logic [1:0] r;
        r = 2'd0;
        for (int i = Q_BITS - 1; i >= 0; i--) begin
            case ({r, a[i]})
                3'b000:  r = 2'd0;
                3'b001:  r = 2'd1;
                3'b010:  r = 2'd2;
                3'b011:  r = 2'd0;
                3'b100:  r = 2'd1;
                3'b101:  r = 2'd2;
                default: r = 2'd0;
            endcase
        end
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] in_idx_q, in_idx_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [1:0]    t_last_q, t_last_d;
    logic [1:0]    buf_q [NTRU_N];

    logic [1:0] t_in;
    logic [1:0] neg_last;
    logic [1:0] s_val;
    logic       drain;
    logic       accept;
    logic       xfer;
    logic       is_last_out;

    always_comb begin
        t_in = mod3(in_coef);
        if (in_coef[Q_BITS-1]) begin
            t_in = add3(t_in, NEG_ADJ);
        end
    end

    assign drain       = (state_q == ST_DRAIN);
    assign in_ready    = !drain;
    assign accept      = in_valid && in_ready;
    assign is_last_out = (out_idx_q == LAST_IDX);
    assign xfer        = drain && out_ready;
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        t_last_d  = t_last_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (in_idx_q == LAST_IDX) begin
                        state_d   = ST_DRAIN;
                        in_idx_d  = '0;
                        out_idx_d = '0;
                        t_last_d  = t_in;
                    end else begin
                        state_d  = ST_LOAD;
                        in_idx_d = in_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    if (is_last_out) begin
                        state_d   = ST_IDLE;
                        in_idx_d  = '0;
                        out_idx_d = '0;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                in_idx_d  = '0;
                out_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            t_last_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            t_last_q  <= t_last_d;
        end
    end

    // Every slot is rewritten before DRAIN reads it, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[in_idx_q] <= t_in;
        end
    end

    assign neg_last = add3(t_last_q, t_last_q);
    assign s_val    = add3(buf_q[out_idx_q], neg_last);

    assign out_valid = drain;
    assign out_last  = drain && is_last_out;
    assign out_coef  = drain ? {s_val[1], s_val[1] | s_val[0]} : 2'b00;

endmodule

// File: tb/tb_poly_rq_to_s3.sv
// Randomised stream bench for poly_rq_to_s3 against an integer-arithmetic reference model.
module tb_poly_rq_to_s3;

    localparam int N      = 701;
    localparam int Q      = 13;
    localparam int QV     = 1 << Q;
    localparam int HALF   = 1 << (Q - 1);
    localparam int BUDGET = 40 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [Q-1:0] in_coef;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_coef;
    logic         out_last;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    int cf [N];
    int ex [N];

    poly_rq_to_s3 #(.NTRU_N(N), .Q_BITS(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_coef (out_coef),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_t(input int a);
        int v;
        v = (a < HALF) ? a : a - QV;
        return ((v % 3) + 3) % 3;
    endfunction

    function automatic int enc(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 3;
    endfunction

    task automatic build_exp();
        int tl;
        tl = ref_t(cf[N-1]);
        for (int i = 0; i < N; i++) ex[i] = enc((ref_t(cf[i]) + 2 * tl) % 3);
    endtask

    task automatic fill_const(input int idx, input int val);
        for (int i = 0; i < N; i++) cf[i] = 0;
        if (idx >= 0) cf[idx] = val;
        build_exp();
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(7))
                    0: cf[i] = 0;
                    1: cf[i] = HALF - 1;
                    2: cf[i] = HALF;
                    3: cf[i] = HALF + 1;
                    4: cf[i] = QV - 1;
                    5: cf[i] = 1;
                    6: cf[i] = 2;
                    default: cf[i] = 3;
                endcase
            end else begin
                cf[i] = $urandom_range(QV - 1);
            end
        end
        build_exp();
    endtask

    task automatic check_reset_state();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coef", out_coef, 0);
        chk("rst_out_last", out_last, 0);
    endtask

    // One polynomial through the block; abort_at>0 stops after that many accepted inputs.
    task automatic run_poly(input int gap_pct, input int stall_pct, input int junk_pct,
                            input int abort_at);
        int         in_sent = 0;
        int         out_cnt = 0;
        int         cyc = 0;
        int         last_in_cyc = -1;
        bit         first_seen = 0;
        bit         stalled = 0;
        logic [1:0] pc = 2'b00;
        logic       pl = 1'b0;
        while (out_cnt < N && cyc < BUDGET) begin
            @(negedge clk);
            if (abort_at > 0 && in_sent == abort_at) break;
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk("first_out_latency", cyc - last_in_cyc, 1);
                end
                chk("in_ready_drain", in_ready, 0);
                if (stalled) begin
                    chk("stall_coef", out_coef, pc);
                    chk("stall_last", out_last, pl);
                end
            end else begin
                chk("quiet_outputs", {out_last, out_coef}, 0);
            end
            if (in_sent < N) chk("in_ready_load", in_ready, 1);
            if (in_sent < N && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_coef  = Q'(cf[in_sent]);
            end else if (in_sent >= N && $urandom_range(99) < junk_pct) begin
                in_valid = 1'b1;
                in_coef  = Q'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready && in_sent < N) begin
                if (in_sent == N - 1) last_in_cyc = cyc;
                in_sent++;
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid && out_ready) begin
                chk("s_coef", out_coef, ex[out_cnt]);
                chk("s_last", out_last, out_cnt == N - 1);
                out_cnt++;
            end
            stalled = out_valid && !out_ready;
            pc = out_coef;
            pl = out_last;
            cyc++;
        end
        if (abort_at == 0) begin
            chk("poly_done", out_cnt, N);
            @(negedge clk);
            in_valid = 1'b0;
            chk("back_to_idle", {busy, in_ready, out_valid}, 3'b010);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        fill_const(-1, 0);
        run_poly(0, 0, 0, 0);
        fill_const(0, 1);
        run_poly(0, 0, 0, 0);
        fill_const(N - 1, 1);
        run_poly(0, 0, 0, 0);
        fill_const(0, HALF - 1);
        run_poly(0, 0, 0, 0);
        fill_const(0, HALF);
        run_poly(0, 0, 0, 0);
        fill_const(0, QV - 1);
        run_poly(0, 0, 0, 0);
        fill_const(0, HALF + 1);
        run_poly(0, 0, 0, 0);

        for (int p = 0; p < 3; p++) begin
            fill_rand();
            run_poly(30, 30, 50, 0);
        end

        fill_rand();
        run_poly(20, 20, 0, 350);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_reset_state();
        rst = 1'b1;
        fill_rand();
        run_poly(20, 20, 50, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
